flag_window_ctrl: RTL and testbench

- Controller that sequences a serial flag detector over a programmed window of input bits and counts the flags found.
- Software pulses start with a window length. The block accepts exactly that many valid serial bits, feeds them to an internal detector, counts detections, then reports done with the count.
- Sits between the serial bit source and the status/counter logic of the counter-and-detector design.

---
 rtl/flag_window_ctrl_pkg.sv | 44 ++++
 rtl/flag_window_ctrl_det_core.sv | 27 ++
 rtl/flag_window_ctrl.sv | 105 ++++++++++
 tb/tb_flag_window_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/flag_window_ctrl_pkg.sv
// Shared types and defaults for the flag window controller and its detector.
package flag_window_ctrl_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_t;

    typedef enum logic [2:0] {
        DET_NONE  = 3'd0,
        DET_ZERO  = 3'd1,
        DET_ONES1 = 3'd2,
        DET_ONES2 = 3'd3,
        DET_ONES3 = 3'd4,
        DET_ONES4 = 3'd5,
        DET_ONES5 = 3'd6,
        DET_MATCH = 3'd7
    } det_state_t;

    // A sixth one drops back to NONE so matching waits for a fresh opening zero;
    // MATCH behaves like ZERO because the closing zero opens the next flag.
    function automatic det_state_t det_next(input det_state_t s, input logic b);
        det_state_t n;
        n = DET_NONE;
        case (s)
            DET_NONE:  n = b ? DET_NONE  : DET_ZERO;
            DET_ZERO:  n = b ? DET_ONES1 : DET_ZERO;
            DET_ONES1: n = b ? DET_ONES2 : DET_ZERO;
            DET_ONES2: n = b ? DET_ONES3 : DET_ZERO;
            DET_ONES3: n = b ? DET_ONES4 : DET_ZERO;
            DET_ONES4: n = b ? DET_ONES5 : DET_ZERO;
            DET_ONES5: n = b ? DET_NONE  : DET_MATCH;
            DET_MATCH: n = b ? DET_ONES1 : DET_ZERO;
            default:   n = DET_NONE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/flag_window_ctrl_det_core.sv
// Serial detector for the flag 0,1,1,1,1,1,0; steps only when adv is high.
module flag_det_core
    import flag_window_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    input  logic in_bit,
    output logic hit,
    output logic matched
);

    det_state_t state;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            state <= DET_NONE;
        end else if (adv) begin
            state <= det_next(state, in_bit);
        end
    end

    assign hit     = adv && (state == DET_ONES5) && !in_bit;
    assign matched = (state == DET_MATCH);

endmodule

// File: rtl/flag_window_ctrl.sv
// Runs the flag detector over a programmed window of serial bits and counts flags.
module flag_window_ctrl
    import flag_window_ctrl_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] window_len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [LEN_W-1:0] remaining;
    logic             consume;
    logic             last_bit;
    logic             det_hit;
    logic             det_matched_unused;

    // Abort beats a simultaneous bit, so that bit is never consumed.
    assign consume  = in_valid && in_ready && !abort;
    assign last_bit = consume && (remaining == LEN_W'(1));

    flag_det_core u_det (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ST_LOAD),
        .adv     (consume),
        .in_bit  (in_bit),
        .hit     (det_hit),
        .matched (det_matched_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = (remaining == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_RUN);
        busy     = (state == ST_LOAD) || (state == ST_RUN);
        done     = (state == ST_DONE);
    end

    // Count and overflow survive DONE and abort; only LOAD or reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            remaining <= '0;
            hit_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                remaining <= window_len;
            end
            if (state == ST_LOAD) begin
                hit_count <= '0;
                overflow  <= 1'b0;
            end
            if (consume) begin
                remaining <= remaining - LEN_W'(1);
                if (det_hit) begin
                    if (hit_count == CNT_MAX) begin
                        overflow <= 1'b1;
                    end else begin
                        hit_count <= hit_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_flag_window_ctrl.sv
// Bench for flag_window_ctrl: two instances (4-bit and 2-bit counters) against a bit-history model.
module tb_flag_window_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] window_len = 8'd0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;

    logic       a_ready, a_busy, a_done, a_ovf;
    logic [3:0] a_cnt;
    logic       b_ready, b_busy, b_done, b_ovf;
    logic [1:0] b_cnt;

    int   checks = 0;
    int   errors = 0;
    int   hits = 0;
    int   win = 0;
    logic hist[$];
    logic wbits[$];

    flag_window_ctrl #(.LEN_W(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .window_len(window_len), .abort(abort),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(a_ready), .busy(a_busy),
        .done(a_done), .hit_count(a_cnt), .overflow(a_ovf)
    );

    flag_window_ctrl #(.LEN_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .window_len(window_len), .abort(abort),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(b_ready), .busy(b_busy),
        .done(b_done), .hit_count(b_cnt), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL w%0d %s observed=%0d expected=%0d", win, tag, observed, expected);
        end
    endtask

    // Expected counts come from the total number of flags seen in the window.
    task automatic checkState(input logic er, input logic eb, input logic ed);
        int ca;
        int cb;
        ca = (hits > 15) ? 15 : hits;
        cb = (hits > 3) ? 3 : hits;
        checkOutput("a.in_ready",  32'(a_ready), 32'(er));
        checkOutput("a.busy",      32'(a_busy),  32'(eb));
        checkOutput("a.done",      32'(a_done),  32'(ed));
        checkOutput("a.hit_count", 32'(a_cnt),   ca);
        checkOutput("a.overflow",  32'(a_ovf),   32'(hits > 15));
        checkOutput("b.in_ready",  32'(b_ready), 32'(er));
        checkOutput("b.busy",      32'(b_busy),  32'(eb));
        checkOutput("b.done",      32'(b_done),  32'(ed));
        checkOutput("b.hit_count", 32'(b_cnt),   cb);
        checkOutput("b.overflow",  32'(b_ovf),   32'(hits > 3));
    endtask

    // A flag ends at a zero preceded by exactly five ones and a zero, all inside the window.
    task automatic modelConsume(input logic b);
        int n;
        n = hist.size();
        if (b == 1'b0 && n >= 6 && hist[n-6] == 1'b0 && hist[n-5] && hist[n-4]
            && hist[n-3] && hist[n-2] && hist[n-1]) begin
            hits++;
        end
        hist.push_back(b);
    endtask

    task automatic setBits(input string s);
        wbits.delete();
        for (int i = 0; i < s.len(); i++) wbits.push_back(s.getc(i) == 8'h31);
    endtask

    // gap: 0 none, 1 one idle cycle per bit, 2 random 0..2 idle cycles.
    task automatic applyStimulus(input int len, input int gap, input int abort_at, input int reset_at);
        int n_idle;
        win++;
        start = 1'b1;
        window_len = 8'(len);
        abort = 1'($urandom);
        in_valid = 1'($urandom);
        in_bit = 1'($urandom);
        tick();
        checkState(1'b0, 1'b1, 1'b0);
        start = 1'($urandom);
        window_len = 8'($urandom);
        abort = 1'($urandom);
        in_valid = 1'($urandom);
        tick();
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        hits = 0;
        hist.delete();
        if (len == 0) begin
            checkState(1'b0, 1'b0, 1'b1);
            tick();
            checkState(1'b0, 1'b0, 1'b0);
            return;
        end
        checkState(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < len; i++) begin
            n_idle = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 2));
            for (int j = 0; j < n_idle; j++) begin
                in_valid = 1'b0;
                in_bit = 1'($urandom);
                start = 1'($urandom);
                window_len = 8'($urandom);
                tick();
                checkState(1'b1, 1'b1, 1'b0);
            end
            in_valid = 1'b1;
            in_bit = wbits[i];
            start = 1'($urandom);
            abort = (i == abort_at);
            rst = !(i == reset_at);
            tick();
            in_valid = 1'b0;
            start = 1'b0;
            abort = 1'b0;
            rst = 1'b1;
            if (i == reset_at) begin
                hits = 0;
                hist.delete();
                checkState(1'b0, 1'b0, 1'b0);
                tick();
                checkState(1'b0, 1'b0, 1'b0);
                return;
            end
            if (i == abort_at) begin
                checkState(1'b0, 1'b0, 1'b0);
                tick();
                checkState(1'b0, 1'b0, 1'b0);
                return;
            end
            modelConsume(wbits[i]);
            if (i == len - 1) begin
                checkState(1'b0, 1'b0, 1'b1);
                tick();
                checkState(1'b0, 1'b0, 1'b0);
            end else begin
                checkState(1'b1, 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        string s;
        int    len;
        int    ab;
        rst = 1'b0;
        tick();
        tick();
        checkState(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checkState(1'b0, 1'b0, 1'b0);

        setBits("0111110");
        applyStimulus(7, 0, -1, -1);
        setBits("0111110111110");
        applyStimulus(13, 1, -1, -1);
        setBits("01111110");
        applyStimulus(8, 0, -1, -1);
        applyStimulus(0, 0, -1, -1);

        s = "0";
        repeat (5) s = {s, "111110"};
        setBits(s);
        applyStimulus(31, 2, -1, -1);
        s = "0";
        repeat (16) s = {s, "111110"};
        setBits(s);
        applyStimulus(97, 0, -1, -1);

        setBits("01111101111111111111");
        applyStimulus(20, 0, 9, -1);
        setBits("0111110");
        applyStimulus(7, 0, 6, -1);
        setBits("0111110000");
        applyStimulus(10, 0, -1, 5);
        setBits("10");
        applyStimulus(2, 0, -1, -1);

        for (int k = 0; k < 25; k++) begin
            len = $urandom_range(0, 40);
            wbits.delete();
            for (int i = 0; i < len; i++) wbits.push_back($urandom_range(0, 3) != 0);
            ab = -1;
            if (len > 0 && $urandom_range(0, 5) == 0) ab = $urandom_range(0, len - 1);
            applyStimulus(len, $urandom_range(0, 2), ab, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
